// File: rtl/fsqrt_nr_unit.sv
// Iterative Newton-Raphson mantissa square root: table seed for 1/sqrt(d), ITER refinements, then q = d*x.
// Optional macro FSQRT_NR_RSQRT_OUT_EN adds a mode input (q = 1/sqrt(d)) and an rsqrt output.
module fsqrt_nr_unit #(
    parameter int MANT_W   = 24,
    parameter int ITER     = 3,
    parameter int STEP_CYC = 7,
    parameter int LUT_BITS = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MANT_W-1:0] d,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MANT_W-1:0] q,
    output logic              q_sticky,
`ifdef FSQRT_NR_RSQRT_OUT_EN
    input  logic              mode,
    output logic [MANT_W+1:0] rsqrt,
`endif
    output logic              err,
    output logic              busy,
    output logic              stall
);
    localparam int W     = MANT_W + 2;
    localparam int P_W   = MANT_W + W;
    localparam int TAB_N = 1 << LUT_BITS;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SEED  = 3'd1;
    localparam logic [2:0] S_ITER  = 3'd2;
    localparam logic [2:0] S_FINAL = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [3:0]   CNT_LAST = 4'(STEP_CYC - 1);
    localparam logic [2:0]   IT_LAST  = 3'(ITER - 1);
    localparam logic [W-1:0] THREE    = {2'b11, {MANT_W{1'b0}}};

    // Entry i = min(255, round(256/sqrt((i+0.5)/2^LUT_BITS)) - 256), found as the largest r
    // with (2r-1)^2 * (2i+1) <= 4 * 2^(LUT_BITS+17), i.e. r = round(256/sqrt(m)).
    function automatic logic [8*TAB_N-1:0] build_seed_tab();
        logic [8*TAB_N-1:0] tab;
        longint num, den, lo, hi, mid;
        tab = '0;
        num = longint'(1) << (LUT_BITS + 19);
        for (int i = 0; i < TAB_N; i++) begin
            den = longint'(2 * i + 1);
            lo  = 1;
            hi  = 2047;
            while (lo < hi) begin
                mid = (lo + hi + 1) / 2;
                if ((2 * mid - 1) * (2 * mid - 1) * den <= num) lo = mid;
                else hi = mid - 1;
            end
            tab[8*i +: 8] = (lo >= 511) ? 8'hFF : 8'(lo - 256);
        end
        return tab;
    endfunction

    localparam logic [8*TAB_N-1:0] SEED_TAB = build_seed_tab();

    logic [2:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [2:0]        it_q, it_d;
    logic [MANT_W-1:0] opnd_q, opnd_d;
    logic [W-1:0]      x_q, x_d;
    logic [P_W-1:0]    prod_q, prod_d;
    logic [MANT_W-1:0] q_q, q_d;
    logic              sticky_q, sticky_d;
    logic              err_q, err_d;
`ifdef FSQRT_NR_RSQRT_OUT_EN
    logic              mode_q, mode_d;
`else
    logic              mode_q;
    assign mode_q = 1'b0;
`endif

    // Refinement datapath reads only x_q/opnd_q, which hold still for STEP_CYC cycles (multicycle path).
    logic [2*W-1:0]      x2_full, y_full;
    logic [P_W-1:0]      t_full, prod_full;
    logic [W-1:0]        x2, t, corr, x_next, x_seed;
    logic [LUT_BITS-1:0] seed_idx;
    logic [7:0]          seed_entry;
    logic [MANT_W-1:0]   q_fin;
    logic                sticky_fin;

    assign x2_full    = {{W{1'b0}}, x_q} * {{W{1'b0}}, x_q};
    assign x2         = W'(x2_full >> MANT_W);
    assign t_full     = {{MANT_W{1'b0}}, x2} * {{W{1'b0}}, opnd_q};
    assign t          = W'(t_full >> MANT_W);
    assign corr       = THREE - t;
    assign y_full     = {{W{1'b0}}, x_q} * {{W{1'b0}}, corr};
    assign x_next     = W'(y_full >> (MANT_W + 1));
    assign prod_full  = {{W{1'b0}}, opnd_q} * {{MANT_W{1'b0}}, x_q};
    assign seed_idx   = opnd_q[MANT_W-1 -: LUT_BITS];
    assign seed_entry = SEED_TAB[{seed_idx, 3'b000} +: 8];
    assign x_seed     = {2'b01, seed_entry, {(MANT_W-8){1'b0}}};
    assign q_fin      = (|prod_q[P_W-1:2*MANT_W]) ? '1 : prod_q[2*MANT_W-1:MANT_W];
    assign sticky_fin = |prod_q[MANT_W-1:0];

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
        state_d  = state_q;
        cnt_d    = cnt_q;
        it_d     = it_q;
        opnd_d   = opnd_q;
        x_d      = x_q;
        prod_d   = prod_q;
        q_d      = q_q;
        sticky_d = sticky_q;
        err_d    = err_q;
`ifdef FSQRT_NR_RSQRT_OUT_EN
        mode_d   = mode_q;
`endif
        if (flush) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            it_d     = '0;
            q_d      = '0;
            sticky_d = 1'b0;
            err_d    = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (in_valid) begin
                    opnd_d   = d;
                    cnt_d    = '0;
                    it_d     = '0;
                    q_d      = '0;
                    sticky_d = 1'b0;
                    err_d    = (d[MANT_W-1 -: 2] == 2'b00);
`ifdef FSQRT_NR_RSQRT_OUT_EN
                    mode_d   = mode;
`endif
                    state_d  = S_SEED;
                end
                S_SEED: if (err_q) begin
                    state_d = S_DONE;
                end else begin
                    x_d     = x_seed;
                    state_d = S_ITER;
                end
                S_ITER: if (cnt_q == CNT_LAST) begin
                    x_d   = x_next;
                    cnt_d = '0;
                    if (it_q == IT_LAST) begin
                        if (mode_q) begin
                            q_d      = x_next[W-1:2];
                            sticky_d = |x_next[1:0];
                            state_d  = S_DONE;
                        end else begin
                            state_d  = S_FINAL;
                        end
                    end else begin
                        it_d = it_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
                // Two-stage d*x: product register, then saturate/format into q.
                S_FINAL: if (cnt_q == 4'd0) begin
                    prod_d = prod_full;
                    cnt_d  = 4'd1;
                end else begin
                    q_d      = q_fin;
                    sticky_d = sticky_fin;
                    cnt_d    = '0;
                    state_d  = S_DONE;
                end
                S_DONE: if (out_ready) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            it_q     <= '0;
            opnd_q   <= '0;
            x_q      <= '0;
            prod_q   <= '0;
            q_q      <= '0;
            sticky_q <= 1'b0;
            err_q    <= 1'b0;
`ifdef FSQRT_NR_RSQRT_OUT_EN
            mode_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            it_q     <= it_d;
            opnd_q   <= opnd_d;
            x_q      <= x_d;
            prod_q   <= prod_d;
            q_q      <= q_d;
            sticky_q <= sticky_d;
            err_q    <= err_d;
`ifdef FSQRT_NR_RSQRT_OUT_EN
            mode_q   <= mode_d;
`endif
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign stall     = (in_valid & ~in_ready) | busy;
    assign q         = q_q;
    assign q_sticky  = sticky_q;
    assign err       = err_q;
`ifdef FSQRT_NR_RSQRT_OUT_EN
    assign rsqrt     = x_q;
`endif

endmodule

// File: tb/tb_fsqrt_nr_unit.sv
// Bench for fsqrt_nr_unit: vector table, randomized operands against an integer-sqrt model, and
// hand-written flush / hold / reset sequences.
module tb_fsqrt_nr_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] d;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] q;
    logic        q_sticky;
    logic        err;
    logic        busy;
    logic        stall;
`ifdef FSQRT_NR_RSQRT_OUT_EN
    logic        mode;
    logic [25:0] rsqrt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fsqrt_nr_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .d         (d),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q),
        .q_sticky  (q_sticky),
`ifdef FSQRT_NR_RSQRT_OUT_EN
        .mode      (mode),
        .rsqrt     (rsqrt),
`endif
        .err       (err),
        .busy      (busy),
        .stall     (stall)
    );

    typedef struct {
        logic [23:0] d;
        logic        err;
        logic [23:0] q;
        int          lat;
    } vec_t;

    task automatic check(input string name, input bit ok, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // floor(sqrt(d) * 2^24) == floor(sqrt(d_int * 2^24)), exact integer square root.
    function automatic longint ref_sqrt(input logic [23:0] dv);
        longint n, r;
        n = longint'(dv) << 24;
        r = longint'($sqrt(real'(n)));
        while (r * r > n) r--;
        while ((r + 1) * (r + 1) <= n) r++;
        return r;
    endfunction

    function automatic bit close(input longint a, input longint b, input longint tol);
        longint diff;
        diff = a - b;
        return (diff <= tol) && (diff >= -tol);
    endfunction

    function automatic logic [29:0] outs();
        return {q, in_ready, out_valid, q_sticky, err, busy, stall};
    endfunction

    localparam logic [29:0] RESET_OUTS = 30'h20;

    // Called at a negedge with in_ready expected high; returns at a negedge after the result handshake.
    task automatic run_op(input logic [23:0] dv, input int hold,
                          output logic [23:0] q_got, output logic s_got, output logic e_got,
                          output int lat);
        bit stable;
        check("accept_ready", in_ready === 1'b1, in_ready, 1);
        in_valid = 1'b1;
        d        = dv;
        @(negedge clk);
        in_valid = 1'b0;
        d        = '0;
        check("busy_after_accept", {busy, in_ready, stall} === 3'b101, {busy, in_ready, stall}, 3'b101);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check("out_valid_timeout", out_valid === 1'b1, out_valid, 1);
        q_got = q;
        s_got = q_sticky;
        e_got = err;
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            stable = stable && (q === q_got) && (err === e_got) && (q_sticky === s_got)
                     && (out_valid === 1'b1) && (in_ready === 1'b0) && (stall === 1'b1);
        end
        if (hold > 0) check("hold_stable", stable, q, q_got);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("handshake_release", {out_valid, in_ready, busy} === 3'b010, {out_valid, in_ready, busy}, 3'b010);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[7];
        logic [23:0] qg;
        logic        sg, eg;
        int          lat;
        logic [23:0] dv;
        longint      rq;
        bit          ok;

        vecs[0] = '{d: 24'h400000, err: 1'b0, q: 24'h800000, lat: 24};
        vecs[1] = '{d: 24'h800000, err: 1'b0, q: 24'hB504F3, lat: 24};
        vecs[2] = '{d: 24'hFFFFFF, err: 1'b0, q: 24'hFFFFFF, lat: 24};
        vecs[3] = '{d: 24'hC00000, err: 1'b0, q: 24'hDDB3D7, lat: 24};
        vecs[4] = '{d: 24'h200000, err: 1'b1, q: 24'h000000, lat: 1};
        vecs[5] = '{d: 24'h000000, err: 1'b1, q: 24'h000000, lat: 1};
        vecs[6] = '{d: 24'h3FFFFF, err: 1'b1, q: 24'h000000, lat: 1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        d         = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
`ifdef FSQRT_NR_RSQRT_OUT_EN
        mode      = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("reset_outputs", outs() === RESET_OUTS, outs(), RESET_OUTS);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_after_reset", outs() === RESET_OUTS, outs(), RESET_OUTS);
        end

        // Directed vectors
        for (int i = 0; i < $size(vecs); i++) begin
            run_op(vecs[i].d, 0, qg, sg, eg, lat);
            check("latency", lat == vecs[i].lat, lat, vecs[i].lat);
            check("err_flag", eg === vecs[i].err, eg, vecs[i].err);
            if (vecs[i].err)
                check("err_q_zero", {qg, sg} === 25'h0, {qg, sg}, 0);
            else
                check("q_vector", close(longint'(qg), longint'(vecs[i].q), 2), qg, vecs[i].q);
        end

        // Result held with out_ready low, then the next operand goes in the cycle after the handshake
        run_op(24'h800000, 10, qg, sg, eg, lat);
        check("q_hold_op", close(longint'(qg), ref_sqrt(24'h800000), 2), qg, ref_sqrt(24'h800000));
        run_op(24'h400000, 0, qg, sg, eg, lat);
        check("q_back_to_back", close(longint'(qg), ref_sqrt(24'h400000), 2), qg, ref_sqrt(24'h400000));

        // Randomized legal operands against the integer-sqrt model
        for (int i = 0; i < 20; i++) begin
            dv = 24'($urandom_range(32'h400000, 32'hFFFFFF));
            rq = ref_sqrt(dv);
            run_op(dv, 0, qg, sg, eg, lat);
            check("rand_latency", lat == 24, lat, 24);
            check("rand_err", eg === 1'b0, eg, 0);
            check("rand_q", close(longint'(qg), rq, 2), qg, rq);
        end

        // Randomized illegal operands
        for (int i = 0; i < 4; i++) begin
            dv = 24'($urandom_range(32'h0, 32'h3FFFFF));
            run_op(dv, 0, qg, sg, eg, lat);
            check("rand_bad_latency", lat == 1, lat, 1);
            check("rand_bad_result", {eg, qg, sg} === {1'b1, 25'h0}, {eg, qg, sg}, {1'b1, 25'h0});
        end

        // Flush during ITER with a simultaneous new operand offered
        in_valid = 1'b1;
        d        = 24'h800000;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (11) @(negedge clk);
        flush    = 1'b1;
        in_valid = 1'b1;
        d        = 24'h400000;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_to_idle", {busy, in_ready, out_valid} === 3'b010, {busy, in_ready, out_valid}, 3'b010);
        ok = 1'b1;
        repeat (40) begin
            @(negedge clk);
            ok = ok && (out_valid === 1'b0) && (busy === 1'b0);
        end
        check("flush_no_accept", ok, out_valid, 0);
        run_op(24'h800000, 0, qg, sg, eg, lat);
        check("after_flush_latency", lat == 24, lat, 24);
        check("after_flush_q", close(longint'(qg), ref_sqrt(24'h800000), 2), qg, ref_sqrt(24'h800000));

        // Flush in IDLE beats acceptance
        flush    = 1'b1;
        in_valid = 1'b1;
        d        = 24'h800000;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_idle_no_accept", {busy, in_ready} === 2'b01, {busy, in_ready}, 2'b01);

        // Flush in DONE with out_ready clears err and out_valid
        in_valid = 1'b1;
        d        = 24'h100000;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("err_done", {out_valid, err} === 2'b11, {out_valid, err}, 2'b11);
        flush     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        flush     = 1'b0;
        out_ready = 1'b0;
        check("flush_done", {out_valid, err, in_ready} === 3'b001, {out_valid, err, in_ready}, 3'b001);

        // Asynchronous reset mid-operation
        in_valid = 1'b1;
        d        = 24'hC00000;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_reset", outs() === RESET_OUTS, outs(), RESET_OUTS);
        @(negedge clk);
        rst_n = 1'b1;
        ok = 1'b1;
        repeat (30) begin
            @(negedge clk);
            ok = ok && (out_valid === 1'b0) && (in_ready === 1'b1);
        end
        check("reset_discards_op", ok, out_valid, 0);
        run_op(24'hC00000, 0, qg, sg, eg, lat);
        check("after_reset_q", close(longint'(qg), ref_sqrt(24'hC00000), 2), qg, ref_sqrt(24'hC00000));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
